// File: rtl/imm_extend_pipe_pkg.sv
// Shared encodings for the immediate-extend pipeline.
// Extension modes and buffer occupancy states.
package imm_extend_pipe_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extension for all four modes.
// Pure function of the raw field and mode.
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  ext_mode_t         mode_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [DATA_W-1:0] sext;

  assign sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  always_comb begin
    ext_o = '0;
    unique case (mode_i)
      EXT_ZERO:   ext_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
      EXT_SIGN:   ext_o = sext;
      EXT_UPPER:  ext_o = {imm_i, {(DATA_W-IMM_W){1'b0}}};
      EXT_BRANCH: ext_o = {sext[DATA_W-3:0], 2'b00};
      default:    ext_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extend stage with a 2-entry skid buffer.
// InReady is registered so OutReady never reaches it combinationally.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [IMM_W-1:0]  Immediate,
  input  logic [1:0]        ExtMode,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Result
);

  if (DATA_W < IMM_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: DATA_W must be >= IMM_W+2");
  end

  occ_t              state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] ext;
  logic              accept;
  logic              consume;

  imm_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm_i  (Immediate),
    .mode_i (ext_mode_t'(ExtMode)),
    .ext_o  (ext)
  );

  assign accept   = InValid && in_ready_q;
  assign consume  = OutValid && OutReady;
  assign InReady  = in_ready_q;
  assign OutValid = (state_q != OCC_EMPTY);
  assign Result   = out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d = OCC_ONE;
            out_d   = ext;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            out_d = ext;
          end else if (accept) begin
            state_d = OCC_FULL;
            skid_d  = ext;
          end else if (consume) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (consume) begin
            state_d = OCC_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= OCC_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboarded random and directed bench for imm_extend_pipe.
// Second instance covers the narrow 8/16 configuration.
module tb_imm_extend_pipe;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, OutReady;
  logic [15:0] Immediate;
  logic [1:0]  ExtMode;
  logic        InReady, OutValid;
  logic [31:0] Result;

  logic        InValid2;
  logic [7:0]  Immediate2;
  logic [1:0]  ExtMode2;
  logic        InReady2, OutValid2;
  logic [15:0] Result2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res = '0;

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Immediate(Immediate), .ExtMode(ExtMode),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result)
  );

  imm_extend_pipe #(.IMM_W(8), .DATA_W(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .Flush(1'b0),
    .InValid(InValid2), .InReady(InReady2),
    .Immediate(Immediate2), .ExtMode(ExtMode2),
    .OutValid(OutValid2), .OutReady(1'b1),
    .Result(Result2)
  );

  // Reference: arithmetic view of the four extension rules.
  function automatic logic [63:0] model(int iw, int dw,
                                        logic [63:0] imm,
                                        logic [1:0] m);
    longint one, u, s, r;
    one = 1;
    u = longint'(imm);
    s = (u >= (one << (iw - 1))) ? u - (one << iw) : u;
    case (m)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = u * (one << (dw - iw));
      default: r = s * 4;
    endcase
    return 64'(r) & ((64'd1 << dw) - 64'd1);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Input side: record every accepted offer.
  always @(negedge Clk) begin
    if (Reset || Flush) begin
      sb_q.delete();
    end else if (InValid && InReady) begin
      sb_q.push_back(32'(model(16, 32, 64'(Immediate), ExtMode)));
    end
  end

  // Output side: compare every consumed result, and stall stability.
  always @(negedge Clk) begin
    logic [31:0] e;
    if (prev_stall) begin
      check("stall_valid", 64'(OutValid), 64'd1);
      check("stall_stable", 64'(Result), 64'(prev_res));
    end
    if (!Reset && !Flush && OutValid && OutReady) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(Result), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", 64'(Result), 64'(e));
      end
    end
    prev_stall = !Reset && !Flush && OutValid && !OutReady;
    prev_res   = Result;
  end

  task automatic fill_full();
    OutReady  = 1'b0;
    InValid   = 1'b1;
    ExtMode   = 2'd1;
    Immediate = 16'h1111;
    step();
    Immediate = 16'h2222;
    step();
    InValid = 1'b0;
    check("fill_full_ready", 64'(InReady), 64'd0);
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Immediate = '0; ExtMode = '0;
    InValid2 = 1'b0; Immediate2 = '0; ExtMode2 = '0;
    step();
    step();
    check("rst_valid", 64'(OutValid), 64'd0);
    check("rst_ready", 64'(InReady), 64'd1);
    check("rst_result", 64'(Result), 64'd0);
    Reset = 1'b0;
    step();
    check("post_rst_ready", 64'(InReady), 64'd1);

    // Four modes at default widths, one cycle latency each.
    OutReady = 1'b1;
    InValid = 1'b1;
    Immediate = 16'h8004;
    ExtMode = 2'd0; step();
    check("mode_zero", 64'(Result), 64'h0000_8004);
    ExtMode = 2'd1; step();
    check("mode_sign", 64'(Result), 64'hFFFF_8004);
    ExtMode = 2'd2; step();
    check("mode_upper", 64'(Result), 64'h8004_0000);
    ExtMode = 2'd3; step();
    check("mode_branch", 64'(Result), 64'hFFFE_0010);
    check("mode_valid", 64'(OutValid), 64'd1);
    InValid = 1'b0;
    step();

    // Narrow configuration.
    InValid2 = 1'b1;
    Immediate2 = 8'h80;
    ExtMode2 = 2'd1; step();
    check("w8_sign", 64'(Result2), 64'hFF80);
    ExtMode2 = 2'd2; step();
    check("w8_upper", 64'(Result2), 64'h8000);
    ExtMode2 = 2'd3; step();
    check("w8_branch", 64'(Result2), 64'hFE00);
    ExtMode2 = 2'd0; step();
    check("w8_zero", 64'(Result2), 64'h0080);
    check("w8_valid", 64'(OutValid2), 64'd1);
    InValid2 = 1'b0;
    step();

    // Back-pressure into the skid register.
    OutReady = 1'b0;
    InValid = 1'b1;
    ExtMode = 2'd1;
    Immediate = 16'h0001; step();
    check("bp_ready1", 64'(InReady), 64'd1);
    Immediate = 16'h0002; step();
    check("bp_ready2", 64'(InReady), 64'd0);
    Immediate = 16'h0003; step();
    check("bp_hold", 64'(Result), 64'h1);
    OutReady = 1'b1; step();
    check("bp_out2", 64'(Result), 64'h2);
    check("bp_ready3", 64'(InReady), 64'd1);
    step();
    check("bp_out3", 64'(Result), 64'h3);
    InValid = 1'b0;
    step();
    check("bp_empty", 64'(OutValid), 64'd0);

    // Streaming at full rate.
    InValid = 1'b1;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Immediate = 16'($urandom);
      ExtMode = 2'($urandom_range(0, 3));
      step();
      check("stream_ready", 64'(InReady), 64'd1);
      check("stream_valid", 64'(OutValid), 64'd1);
    end
    InValid = 1'b0;
    step();

    // Flush while full with a same-cycle offer.
    fill_full();
    Flush = 1'b1;
    InValid = 1'b1;
    ExtMode = 2'd0;
    Immediate = 16'h00FF;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    check("flush_valid", 64'(OutValid), 64'd0);
    check("flush_ready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_ff", 64'(OutValid), 64'd0);
    end

    // Reset while full.
    fill_full();
    Reset = 1'b1;
    step();
    check("rstf_valid", 64'(OutValid), 64'd0);
    check("rstf_result", 64'(Result), 64'd0);
    check("rstf_ready", 64'(InReady), 64'd1);
    Reset = 1'b0;
    OutReady = 1'b1;
    InValid = 1'b1;
    ExtMode = 2'd1;
    Immediate = 16'hF00D;
    step();
    InValid = 1'b0;
    check("rstf_first", 64'(Result), 64'hFFFF_F00D);
    check("rstf_first_v", 64'(OutValid), 64'd1);
    step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      InValid = 1'($urandom_range(0, 1));
      OutReady = ($urandom_range(0, 3) != 0);
      Flush = ($urandom_range(0, 39) == 0);
      Immediate = 16'($urandom);
      ExtMode = 2'($urandom_range(0, 3));
      step();
    end
    Flush = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    check("drain_valid", 64'(OutValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IMM_W, default 16, width of the raw immediate field.
REQ-002 Parameter DATA_W, default 32, width of the extended result; legal only when DATA_W >= IMM_W+2, and elaboration SHALL fail otherwise.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Flush  input  1  discard every held entry (branch/exception squash).
REQ-006 InValid  input  1  upstream offers Immediate/ExtMode this cycle.
REQ-007 InReady  output  1  block accepts the offer this cycle.
REQ-008 Immediate  input  IMM_W  raw immediate field.
REQ-009 ExtMode  input  2  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH.
REQ-010 OutValid  output  1  Result holds a valid extended value.
REQ-011 OutReady  input  1  downstream consumes Result this cycle.
REQ-012 Result  output  DATA_W  extended value, driven directly from a register.

Function
REQ-013 ZERO SHALL produce {(DATA_W-IMM_W) zeros, Immediate}.
REQ-014 SIGN SHALL produce Immediate[IMM_W-1] replicated over (DATA_W-IMM_W) bits, followed by Immediate.
REQ-015 UPPER SHALL produce Immediate in bits [DATA_W-1 : DATA_W-IMM_W], with all lower bits zero.
REQ-016 BRANCH SHALL produce the SIGN value shifted left by 2 and truncated to DATA_W bits, with bits [1:0] zero.
REQ-017 The block SHALL transfer an input on the cycle where InValid && InReady, and an output on the cycle where OutValid && OutReady.
REQ-018 The block SHALL hold a 2-entry buffer: an output register plus one skid register.
REQ-019 Extension SHALL be computed at acceptance time, and both registers SHALL store extended values.
REQ-020 Latency SHALL be 1 cycle: a transfer accepted at edge N SHALL appear on Result with OutValid=1 after edge N when the output register is empty or draining.
REQ-021 InReady SHALL be a registered signal equal to "skid register empty", with no combinational path from OutReady.
REQ-022 Occupancy states SHALL be EMPTY (0), ONE (output register valid), and FULL (output and skid registers valid).
REQ-023 EMPTY+accept SHALL transition to ONE.
REQ-024 ONE with accept and no consume SHALL transition to FULL, and the new value SHALL be written to the skid register.
REQ-025 ONE with accept and consume SHALL stay in ONE, and the output register SHALL load the new value.
REQ-026 ONE with consume and no accept SHALL transition to EMPTY.
REQ-027 FULL with consume SHALL transition to ONE, and the skid value SHALL move to the output register; accept is impossible in FULL because InReady=0.
REQ-028 Transfers SHALL be in order, with no duplication or loss except by Flush/Reset.
REQ-029 While OutValid=1 and OutReady=0, Result SHALL stay stable.
REQ-030 Flush SHALL force EMPTY at the next edge, discard any same-cycle input, and drive InReady=1 the cycle after; Flush takes priority over accept and consume.
REQ-031 Result value while OutValid=0 is don't-care but SHALL be deterministic: it keeps its last value and is zero after reset.

Reset
REQ-032 On Reset=1 at an edge, the block SHALL enter EMPTY with OutValid=0, InReady=1 and Result=0, and skid contents are discarded.
REQ-033 Reset SHALL dominate Flush and all handshakes, and reset asserted mid-transfer SHALL lose that transfer.
REQ-034 InReady SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the ExtMode encodings (EXT_ZERO=0, EXT_SIGN=1, EXT_UPPER=2, EXT_BRANCH=3) and the 2-bit mode typedef.
REQ-036 The combinational mode function SHALL be a sub-module named imm_ext_core, parameterised by IMM_W and DATA_W, and instantiated once on the input path.
REQ-037 Occupancy SHALL be an explicit 2-bit state register using the encodings EMPTY, ONE and FULL.

Verification
REQ-038 Modes at default widths:
- Immediate=16'h8004 in ZERO -> 32'h00008004.
- SIGN -> 32'hFFFF8004.
- UPPER -> 32'h80040000.
- BRANCH -> 32'hFFFE0010.
- Each SHALL appear 1 cycle after accept.
REQ-039 Back-pressure: send 16'h0001, 16'h0002, 16'h0003 in SIGN on consecutive cycles with OutReady=0.
- InReady SHALL drop after the 2nd accept.
- Result SHALL hold 32'h00000001.
- After OutReady=1, outputs SHALL be 1, 2, 3 in order, with no loss.
REQ-040 Streaming: InValid=OutReady=1 continuously for 8 cycles -> throughput of one result per cycle, and InReady SHALL never drop.
REQ-041 Flush in FULL with InValid=1 (Immediate=16'h00FF) -> next cycle OutValid=0 and InReady=1, and 32'h000000FF SHALL never appear.
REQ-042 Reset asserted while FULL -> next cycle OutValid=0, Result=0, InReady=1, and the first post-reset accept SHALL appear normally.
REQ-043 Parameter check: IMM_W=8, DATA_W=16, Immediate=8'h80 -> SIGN 16'hFF80, UPPER 16'h8000, BRANCH 16'hFE00.
